interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Prioritised, maskable interrupt controller between the raw IRQ[2:0] pins and the pipelined CPU.
- Synchronises and edge-detects the request lines, latches pending requests and arbitrates by fixed priority (line 2 highest).
- Hands one request at a time to the CPU with a req/ack handshake and a vector.
- Tracks in-service levels until ERET and drives the IRW status LEDs.

Parameters:
- N_IRQ, 3, number of interrupt lines (index N_IRQ-1 highest priority).
- WIDTH, 32, width of the vector output and datapath words.
- VEC_BASE, 32'h0000_0800, vector address of line 0.
- VEC_STRIDE, 32'h0000_0040, address distance between consecutive line vectors.

Ports:
- clk  in  1  system clock (CPU clock domain); single clock.
- rst  in  1  synchronous, active-high reset.
- irq  in  N_IRQ  raw asynchronous request pins, level high = requesting.
- ie  in  1  CPU global interrupt enable.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  N_IRQ  new mask value; 1 = line enabled.
- int_ack  in  1  one-cycle pulse; CPU has taken the presented interrupt.
- eret  in  1  one-cycle pulse; CPU has returned from the current handler.
- int_req  out  1  interrupt request to the CPU.
- int_id  out  2  index of the presented line.
- int_vec  out  WIDTH  VEC_BASE + int_id*VEC_STRIDE.
- irw  out  N_IRQ  status per line: pending OR in-service.

Behaviour:
- Reset values (next edge with rst=1):
  - sync stages, pending, in_service, int_req, int_id all 0.
  - mask all 1; FSM IDLE; int_vec = VEC_BASE; irw = 0.
  - rst mid-handshake abandons the request with no ack expected, and clears all in-service levels.
- Synchroniser:
  - s1<=irq, s2<=s1, s3<=s2; rise = s2 & ~s3.
  - Edge-triggered: a held pin produces one request only.
- Latency:
  - IRQ first sampled high at edge k gives pending set after edge k+2 and int_req high after edge k+3, if eligible.
- pending:
  - pending <= (pending & ~clr) | rise.
  - clr is the one-hot of int_id on the int_ack cycle.
  - A rise on the acked line in the same cycle wins: the bit stays set.
- Eligibility:
  - eligible = pending & mask.
  - cand = highest set bit of eligible.
  - cur = highest set bit of in_service (none = -1).
  - Request allowed when ie=1, eligible != 0, and cand > cur.
- FSM:
  - IDLE: if request allowed, latch int_id<=cand, set int_req=1, go REQ.
  - REQ: int_id and int_vec are frozen. Higher-priority rises only pend.
  - REQ, on int_ack: in_service[int_id]<=1, int_req<=0, go IDLE.
  - REQ, on ie=0 or mask[int_id]=0 with no int_ack that cycle: withdraw (int_req<=0, go IDLE). The pending bit is kept.
  - The earliest re-request after ack is the cycle after returning to IDLE.
- eret:
  - Clears the highest set bit of in_service. No effect if in_service=0.
  - eret and int_ack in the same cycle: the eret clear is applied first, then the ack set. The result is registered together.
- Mask:
  - mask_we updates the mask at the edge. Effect is visible to eligibility the following cycle.
  - Masked lines still latch pending.
- int_ack while in IDLE is ignored.
- int_vec is combinational from registered int_id, so it is glitch-free.

Optional Feature:
- Macro: NESTED_INT_EN.
- Defined: nesting as above. A higher-priority line preempts a running lower handler; in_service may hold several bits.
- Undefined: request allowed only when in_service==0, so single-level service with no preemption. in_service holds at most one bit, and eret clears it.

Decomposition:
- Package intc_pkg:
  - FSM state enum (IDLE, REQ).
  - Default VEC_BASE and VEC_STRIDE constants.
  - Function prio_enc returning the highest set index plus a valid flag.
- Sub-module irq_sync_edge: parameterised N-bit 3-stage synchroniser plus rise detector. Instantiated once.

Test Plan:
- Reset: after rst, check int_req=0, irw=0, int_vec=32'h800. Pulse irq[1] for 3 cycles with ie=1 -> int_req rises after edge k+3 with int_id=1, int_vec=32'h840.
- Ack/eret:
  - int_ack in REQ -> int_req falls next edge and irw[1] stays 1 (in-service).
  - eret -> irw[1]=0.
  - Holding irq[1] high for the whole test produces no second request.
- Simultaneous: raise irq[0] and irq[2] in the same cycle -> int_id=2, vector 32'h880. After ack and eret, line 0 is presented, int_id=0, vector 32'h800.
- Nesting (NESTED_INT_EN defined): line 0 in service, then irq[2] -> new request int_id=2 while irw=3'b101. After eret, irw=3'b001. Undefined build: no request until line 0's eret.
- Masking/withdraw:
  - mask_wdata=3'b011 then irq[2] -> no int_req, irw[2]=1. Unmask -> request id 2.
  - Drop ie during REQ -> int_req falls, pending kept. Restoring ie re-requests.
- Edge cases:
  - int_ack coincident with a new rise on the same line -> line re-presented after return to IDLE.
  - rst asserted while in REQ -> all outputs back to reset values next edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and helpers for the interrupt controller.
// Used by the controller in both NESTED_INT_EN builds.
package intc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;

  // Widest line set the 2-bit int_id can name.
  localparam int MAX_LINES = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } prio_t;

  // Highest set index wins; valid=0 when nothing is set.
  function automatic prio_t prio_enc(input logic [MAX_LINES-1:0] v);
    prio_t r;
    r = '0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side bundle of the interrupt controller.
// Handshake: int_req stays high with int_id/int_vec frozen until a one-cycle
// int_ack (taken) or until the controller withdraws it; eret pulses end a handler.
interface interrupt_controller_if #(
  parameter int N_IRQ = 3,
  parameter int WIDTH = 32
);
  logic [N_IRQ-1:0] irq;
  logic             ie;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             int_ack;
  logic             eret;
  logic             int_req;
  logic [1:0]       int_id;
  logic [WIDTH-1:0] int_vec;
  logic [N_IRQ-1:0] irw;

  modport master (
    output irq, ie, mask_we, mask_wdata, int_ack, eret,
    input  int_req, int_id, int_vec, irw
  );

  modport slave (
    input  irq, ie, mask_we, mask_wdata, int_ack, eret,
    output int_req, int_id, int_vec, irw
  );
endinterface

// File: rtl/interrupt_controller_irq_sync_edge.sv
// N-bit three-flop synchroniser with rising-edge detect on the last two stages.
module irq_sync_edge #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_async,
  output logic [N-1:0] o_rise
);
  logic [N-1:0] r_s1, r_s2, r_s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, maskable interrupt controller (line N_IRQ-1 highest).
// Define NESTED_INT_EN to let higher-priority lines preempt running handlers.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int               N_IRQ      = 3,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(VEC_BASE_DEF),
  parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(VEC_STRIDE_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_controller_if.slave  bus,
  output state_e                 o_dbg_state
);
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] r_pending, r_in_service, r_mask;
  logic [N_IRQ-1:0] w_elig, w_ack_set, w_eret_clr, w_id_onehot;
  logic             r_int_req, w_allow, w_ack, w_withdraw;
  logic [1:0]       r_int_id;
  state_e           r_state;
  prio_t            w_cand, w_cur;

  irq_sync_edge #(.N(N_IRQ)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.irq),
    .o_rise  (w_rise)
  );

  always_comb begin
    w_elig      = r_pending & r_mask;
    w_cand      = prio_enc(MAX_LINES'(w_elig));
    w_cur       = prio_enc(MAX_LINES'(r_in_service));
    w_id_onehot = N_IRQ'(1) << r_int_id;
`ifdef NESTED_INT_EN
    w_allow = bus.ie && w_cand.valid && (!w_cur.valid || (w_cand.idx > w_cur.idx));
`else
    w_allow = bus.ie && w_cand.valid && !w_cur.valid;
`endif
    w_ack      = (r_state == ST_REQ) && bus.int_ack;
    w_withdraw = !bus.ie || !r_mask[r_int_id];
    w_ack_set  = w_ack ? w_id_onehot : '0;
    // eret retires the highest in-service level before any same-cycle ack lands.
    w_eret_clr = (bus.eret && w_cur.valid) ? (N_IRQ'(1) << w_cur.idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_mask       <= '1;
      r_int_req    <= 1'b0;
      r_int_id     <= '0;
      r_state      <= ST_IDLE;
    end else begin
      // A fresh rise on the line being acked keeps its pending bit.
      r_pending    <= (r_pending & ~w_ack_set) | w_rise;
      r_in_service <= (r_in_service & ~w_eret_clr) | w_ack_set;
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      case (r_state)
        ST_IDLE: begin
          if (w_allow) begin
            r_int_id  <= w_cand.idx;
            r_int_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.int_ack || w_withdraw) begin
            r_int_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_int_req <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.int_req  = r_int_req;
  assign bus.int_id   = r_int_id;
  assign bus.int_vec  = VEC_BASE + (WIDTH'(r_int_id) * VEC_STRIDE);
  assign bus.irw      = r_pending | r_in_service;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller; expected vectors queued at stimulus time.
module tb_interrupt_controller;
  import intc_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  interrupt_controller_if #(.N_IRQ(3), .WIDTH(32)) ifc ();

  interrupt_controller dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (ifc),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ack();
    ifc.int_ack = 1'b1;
    tick(1);
    ifc.int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    ifc.eret = 1'b1;
    tick(1);
    ifc.eret = 1'b0;
  endtask

  task automatic set_mask(input logic [2:0] m);
    ifc.mask_we    = 1'b1;
    ifc.mask_wdata = m;
    tick(1);
    ifc.mask_we    = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n;
    n = 0;
    while (ifc.int_req !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_req_seen"}, 32'(ifc.int_req), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_id"}, 32'(ifc.int_id), 32'(e));
      check({tag, "_vec"}, ifc.int_vec, 32'h800 + 32'(e) * 32'h40);
    end
  endtask

  initial begin
    rst            = 1'b1;
    ifc.irq        = '0;
    ifc.ie         = 1'b0;
    ifc.mask_we    = 1'b0;
    ifc.mask_wdata = '0;
    ifc.int_ack    = 1'b0;
    ifc.eret       = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_req",   32'(ifc.int_req), 32'd0);
    check("rst_irw",   32'(ifc.irw), 32'd0);
    check("rst_vec",   ifc.int_vec, 32'h800);
    check("rst_id",    32'(ifc.int_id), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Line 1 latency; the pin stays high for the rest of the run.
    ifc.ie  = 1'b1;
    ifc.irq = 3'b010;
    exp_q.push_back(2'd1);
    tick(3);
    check("lat_no_req_k2", 32'(ifc.int_req), 32'd0);
    check("lat_pend_k2",   32'(ifc.irw), 32'b010);
    tick(1);
    check("lat_req_k3",    32'(ifc.int_req), 32'd1);
    check("lat_state_k3",  32'(dbg_state), 32'(ST_REQ));
    pop_check("l1");
    pulse_ack();
    check("ack_req_low", 32'(ifc.int_req), 32'd0);
    check("ack_irw",     32'(ifc.irw), 32'b010);
    tick(3);
    check("ack_no_rereq", 32'(ifc.int_req), 32'd0);
    pulse_eret();
    check("eret_irw", 32'(ifc.irw), 32'd0);
    tick(6);
    check("held_no_second", 32'(ifc.int_req), 32'd0);

    // Simultaneous lines 0 and 2.
    ifc.irq = 3'b111;
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    wait_req("sim2", 20);
    pop_check("sim2");
    pulse_ack();
    tick(3);
    check("sim_block_l0", 32'(ifc.int_req), 32'd0);
    check("sim_irw_101",  32'(ifc.irw), 32'b101);
    pulse_eret();
    wait_req("sim0", 20);
    pop_check("sim0");
    pulse_ack();
    pulse_eret();
    check("sim_irw_clear", 32'(ifc.irw), 32'd0);
    ifc.irq = 3'b010;
    tick(4);

    // Line 0 in service, then line 2 arrives.
    ifc.irq = 3'b011;
    exp_q.push_back(2'd0);
    wait_req("nest0", 20);
    pop_check("nest0");
    pulse_ack();
    ifc.irq = 3'b111;
`ifdef NESTED_INT_EN
    exp_q.push_back(2'd2);
    wait_req("nest2", 20);
    check("nest_irw_101", 32'(ifc.irw), 32'b101);
    pop_check("nest2");
    pulse_ack();
    check("nest_is_101", 32'(ifc.irw), 32'b101);
    pulse_eret();
    check("nest_irw_001", 32'(ifc.irw), 32'b001);
    pulse_eret();
`else
    tick(8);
    check("flat_no_preempt", 32'(ifc.int_req), 32'd0);
    check("flat_irw_101",    32'(ifc.irw), 32'b101);
    pulse_eret();
    exp_q.push_back(2'd2);
    wait_req("flat2", 20);
    pop_check("flat2");
    pulse_ack();
    pulse_eret();
`endif
    check("nest_irw_clear", 32'(ifc.irw), 32'd0);
    ifc.irq = 3'b010;
    tick(4);

    // Masked line still pends; unmask presents it; dropping ie withdraws.
    set_mask(3'b011);
    ifc.irq = 3'b110;
    tick(8);
    check("mask_no_req", 32'(ifc.int_req), 32'd0);
    check("mask_pend",   32'(ifc.irw), 32'b100);
    set_mask(3'b111);
    exp_q.push_back(2'd2);
    wait_req("unmask", 20);
    pop_check("unmask");
    ifc.ie = 1'b0;
    tick(1);
    check("wd_req_low", 32'(ifc.int_req), 32'd0);
    check("wd_pend",    32'(ifc.irw), 32'b100);
    tick(3);
    check("wd_stays_low", 32'(ifc.int_req), 32'd0);
    ifc.ie = 1'b1;
    exp_q.push_back(2'd2);
    wait_req("rereq", 20);
    pop_check("rereq");
    pulse_ack();
    pulse_eret();
    check("mask_irw_clear", 32'(ifc.irw), 32'd0);

    // Ack lands in the same cycle as a new rise on line 0.
    ifc.irq = 3'b111;
    exp_q.push_back(2'd0);
    wait_req("race0", 20);
    pop_check("race0");
    ifc.irq = 3'b110;
    tick(3);
    ifc.irq = 3'b111;
    tick(2);
    pulse_ack();
    check("race_req_low", 32'(ifc.int_req), 32'd0);
    check("race_irw",     32'(ifc.irw), 32'b001);
    pulse_eret();
    check("race_pend_kept", 32'(ifc.irw), 32'b001);
    exp_q.push_back(2'd0);
    wait_req("race_again", 20);
    pop_check("race_again");
    pulse_ack();
    pulse_eret();
    check("race_irw_clear", 32'(ifc.irw), 32'd0);

    // Reset while a request is outstanding.
    ifc.irq = 3'b010;
    tick(4);
    ifc.irq = 3'b110;
    exp_q.push_back(2'd2);
    wait_req("rstreq", 20);
    pop_check("rstreq");
    rst = 1'b1;
    tick(1);
    check("rstmid_req",   32'(ifc.int_req), 32'd0);
    check("rstmid_irw",   32'(ifc.irw), 32'd0);
    check("rstmid_vec",   ifc.int_vec, 32'h800);
    check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    ifc.irq = 3'b000;
    rst     = 1'b0;
    tick(6);
    check("post_rst_idle", 32'(ifc.int_req), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
